// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, ALU operation, state and instruction-field definitions
package cpu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_NOT, ALU_LD
    } alu_op_e;
    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_e;
    localparam logic [3:0] OPC_NOP  = 4'h7;
    localparam logic [3:0] OPC_JMP  = 4'h8;
    localparam logic [3:0] OPC_JC   = 4'h9;
    localparam logic [3:0] OPC_JZ   = 4'hA;
    localparam logic [3:0] OPC_ST   = 4'hB;
    localparam logic [3:0] OPC_HALT = 4'hF;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int SRC_BIT = 11;
    localparam int RSV_BIT = 10;
    localparam int IDX_MSB = 9;
    localparam int IDX_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
endpackage

// File: rtl/reg_file.sv
// reg_file: general registers, one combinational read port, one synchronous write port
module reg_file #(
    parameter int NUM_REGS = 4,
    parameter int W        = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   raddr_i,
    output logic [W-1:0] rdata_o,
    input  logic         we_i,
    input  logic [1:0]   waddr_i,
    input  logic [W-1:0] wdata_i
);
    logic [W-1:0] mem_q [NUM_REGS];

    assign rdata_o = mem_q[raddr_i];

    // register array with asynchronous clear to zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: fetch/execute sequencer for the 8-bit accumulator datapath
module cpu_control
    import cpu_pkg::*;
#(
    parameter int                    PC_WIDTH = 8,
    parameter int                    NUM_REGS = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [PC_WIDTH-1:0] OUT_PC,
    output logic                OUT_MEM_REQ,
    input  logic                IN_MEM_ACK,
    input  logic [15:0]         IN_MEM_DATA,
    output logic [7:0]          OUT_ALU_A,
    output logic [7:0]          OUT_ALU_R,
    output logic [2:0]          OUT_ALU_OP,
    input  logic [7:0]          IN_ALU_RES,
    input  logic                IN_ALU_CY,
    output logic [7:0]          OUT_ACC,
    output logic                OUT_CY,
    output logic                OUT_Z,
    output logic                OUT_HALTED
);
    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [7:0]          acc_q, acc_d;
    logic                cy_q, cy_d, z_q, z_d;
    logic [3:0]          opc;
    logic [7:0]          reg_rd;
    logic                reg_we, is_alu, taken;
    logic                unused_rsvd;

    assign opc         = ir_q[OPC_MSB:OPC_LSB];
    assign unused_rsvd = ir_q[RSV_BIT];
    assign is_alu      = !opc[3] && opc != OPC_NOP;
    assign taken       = opc == OPC_JMP || (opc == OPC_JC && cy_q) || (opc == OPC_JZ && z_q);

    // request is gated by RST so it drops the moment reset is asserted
    assign OUT_MEM_REQ = state_q == FETCH && !RST;
    assign OUT_HALTED  = state_q == HALTED;
    assign OUT_PC      = pc_q;
    assign OUT_ALU_A   = acc_q;
    assign OUT_ALU_OP  = ir_q[14:12];
    assign OUT_ALU_R   = ir_q[SRC_BIT] ? reg_rd : ir_q[IMM_MSB:IMM_LSB];
    assign OUT_ACC     = acc_q;
    assign OUT_CY      = cy_q;
    assign OUT_Z       = z_q;

    reg_file #(.NUM_REGS(NUM_REGS), .W(8)) u_reg_file (
        .clk_i  (CLK),
        .rst_i  (RST),
        .raddr_i(ir_q[IDX_MSB:IDX_LSB]),
        .rdata_o(reg_rd),
        .we_i   (reg_we),
        .waddr_i(ir_q[IDX_MSB:IDX_LSB]),
        .wdata_i(acc_q)
    );

    // next state: latch the instruction on ack, commit all EXEC effects in one cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        cy_d    = cy_q;
        z_d     = z_q;
        reg_we  = 1'b0;
        case (state_q)
            FETCH: begin
                if (IN_MEM_ACK) begin
                    ir_d    = IN_MEM_DATA;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = opc == OPC_HALT ? HALTED : FETCH;
                pc_d    = opc == OPC_HALT ? pc_q : taken ? ir_q[PC_WIDTH-1:0] : pc_q + 1'b1;
                reg_we  = opc == OPC_ST;
                if (is_alu) begin
                    acc_d = IN_ALU_RES;
                    cy_d  = IN_ALU_CY;
                    z_d   = IN_ALU_RES == 8'h00;
                end
            end
            default: ;
        endcase
    end

    // architectural state with asynchronous clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            cy_q    <= cy_d;
            z_q     <= z_d;
        end
    end
endmodule
